// File: rtl/round_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : round_scoreboard
// Brief    : Game sequencer fed by the 1 Hz round counter. Runs NUM_ROUNDS
//            rounds, accumulates a saturating score from hit pulses, reports
//            the remaining round time and flags the end of the game.
//            Optional feature macro: HISCORE_EN (adds the hi_score output,
//            which holds the best final score across games).
// Revision : 1.0 - initial release
// ============================================================================
module round_scoreboard #(
    parameter int ROUND_LEN  = 12,
    parameter int NUM_ROUNDS = 5,
    parameter int SCORE_W    = 8,
    parameter int HIT_PTS    = 1
) (
    input  logic               clock_div_1Hz,
    input  logic               total_reset,
    input  logic               start,
    input  logic               hit,
    input  logic [6:0]         current_time,
    input  logic               round_reset,
    output logic [1:0]         state,
    output logic [3:0]         round_num,
    output logic [SCORE_W-1:0] score,
    output logic [6:0]         time_left,
    output logic               round_done,
    output logic               game_over
`ifdef HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hi_score
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [6:0]         c_round_len  = 7'(ROUND_LEN);
    localparam logic [3:0]         c_last_round = 4'(NUM_ROUNDS - 1);
    localparam logic [SCORE_W-1:0] c_score_max  = '1;
    localparam logic [SCORE_W:0]   c_hit_pts    = (SCORE_W + 1)'(HIT_PTS);

    state_t             r_state;
    logic [3:0]         r_round_num;
    logic [SCORE_W-1:0] r_score;
    logic               r_round_done;
    logic               r_game_over;
`ifdef HISCORE_EN
    logic [SCORE_W-1:0] r_hi_score;
`endif

    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_inc;

    // Saturating score increment: one extra bit catches the overflow.
    always_comb begin
        w_score_sum = {1'b0, r_score} + c_hit_pts;
        w_score_inc = (w_score_sum > {1'b0, c_score_max}) ? c_score_max
                                                          : w_score_sum[SCORE_W-1:0];
    end

    // Remaining time clamps at zero if the counter ever overshoots the round length.
    always_comb begin
        time_left = (current_time > c_round_len) ? 7'd0 : (c_round_len - current_time);
    end

    // Game sequencer: all state-like outputs are registered here.
    always_ff @(posedge clock_div_1Hz) begin
        if (!total_reset) begin
            r_state      <= ST_IDLE;
            r_round_num  <= 4'd0;
            r_score      <= '0;
            r_round_done <= 1'b0;
            r_game_over  <= 1'b0;
`ifdef HISCORE_EN
            r_hi_score   <= '0;
`endif
        end else begin
            // round_done is a single-cycle pulse; only a PLAY boundary raises it.
            r_round_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // round_reset low right after counter reset must not start a game.
                    if (start && round_reset) begin
                        r_state     <= ST_PLAY;
                        r_score     <= '0;
                        r_round_num <= 4'd0;
                    end
                end
                ST_PLAY: begin
                    if (!round_reset) begin
                        // Boundary: a hit in the same cycle is deliberately dropped.
                        r_round_done <= 1'b1;
                        if (r_round_num < c_last_round) begin
                            r_round_num <= r_round_num + 4'd1;
                        end else begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
`ifdef HISCORE_EN
                            if (r_score > r_hi_score) begin
                                r_hi_score <= r_score;
                            end
`endif
                        end
                    end else if (hit) begin
                        r_score <= w_score_inc;
                    end
                end
                ST_OVER: begin
                    // Player must release start before a new game can begin.
                    if (!start) begin
                        r_state     <= ST_IDLE;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign round_num  = r_round_num;
    assign score      = r_score;
    assign round_done = r_round_done;
    assign game_over  = r_game_over;
`ifdef HISCORE_EN
    assign hi_score   = r_hi_score;
`endif

endmodule
`default_nettype wire
